// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one downstream memory request port between IFU and LSU.
// Optional macro MEM_ARB_RR_EN selects round-robin instead of fixed LSU > IFU priority.
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int MASK_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ifu_valid_i,
    input  logic [ADDR_W-1:0] ifu_addr_i,
    output logic              ifu_ready_o,
    output logic [DATA_W-1:0] ifu_rdata_o,
    input  logic              lsu_valid_i,
    input  logic [ADDR_W-1:0] lsu_addr_i,
    input  logic              lsu_ren_i,
    input  logic              lsu_wen_i,
    input  logic [MASK_W-1:0] lsu_mask_i,
    input  logic [2:0]        lsu_size_i,
    input  logic [DATA_W-1:0] lsu_wdata_i,
    output logic              lsu_ready_o,
    output logic [DATA_W-1:0] lsu_rdata_o,
    output logic              mem_valid_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_ren_o,
    output logic              mem_wen_o,
    output logic [MASK_W-1:0] mem_mask_o,
    output logic [2:0]        mem_size_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ready_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic [1:0]        grant_o
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BUSY_IFU = 2'd1,
        BUSY_LSU = 2'd2
    } state_e;

    state_e            state_q;
    logic              valid_q;
    logic [ADDR_W-1:0] addr_q;
    logic              ren_q;
    logic              wen_q;
    logic [MASK_W-1:0] mask_q;
    logic [2:0]        size_q;
    logic [DATA_W-1:0] wdata_q;
    logic              pick_lsu;

`ifdef MEM_ARB_RR_EN
    // 1 = LSU won the most recent grant, 0 = IFU did
    logic last_lsu_q;

    // On contention, favour whoever did not win last time
    always_comb pick_lsu = lsu_valid_i && (!ifu_valid_i || !last_lsu_q);
`else
    // Fixed priority: LSU always beats IFU
    always_comb pick_lsu = lsu_valid_i;
`endif

    // Arbitration FSM with registered downstream payload
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            addr_q  <= '0;
            ren_q   <= 1'b0;
            wen_q   <= 1'b0;
            mask_q  <= '0;
            size_q  <= 3'b000;
            wdata_q <= '0;
`ifdef MEM_ARB_RR_EN
            last_lsu_q <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (lsu_valid_i || ifu_valid_i) begin
                        valid_q <= 1'b1;
                        if (pick_lsu) begin
                            state_q <= BUSY_LSU;
                            addr_q  <= lsu_addr_i;
                            ren_q   <= lsu_ren_i;
                            wen_q   <= lsu_wen_i;
                            mask_q  <= lsu_mask_i;
                            size_q  <= lsu_size_i;
                            wdata_q <= lsu_wdata_i;
                        end else begin
                            state_q <= BUSY_IFU;
                            addr_q  <= ifu_addr_i;
                            ren_q   <= 1'b1;
                            wen_q   <= 1'b0;
                            mask_q  <= '1;
                            size_q  <= 3'b010;
                            wdata_q <= '0;
                        end
`ifdef MEM_ARB_RR_EN
                        last_lsu_q <= pick_lsu;
`endif
                    end
                end
                BUSY_IFU, BUSY_LSU: begin
                    if (mem_ready_i) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                        addr_q  <= '0;
                        ren_q   <= 1'b0;
                        wen_q   <= 1'b0;
                        mask_q  <= '0;
                        size_q  <= 3'b000;
                        wdata_q <= '0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Completion pulse and read data steered to the current owner only
    always_comb begin
        ifu_ready_o = (state_q == BUSY_IFU) && mem_ready_i;
        lsu_ready_o = (state_q == BUSY_LSU) && mem_ready_i;
        ifu_rdata_o = ifu_ready_o ? mem_rdata_i : '0;
        lsu_rdata_o = lsu_ready_o ? mem_rdata_i : '0;
        grant_o     = {state_q == BUSY_LSU, state_q == BUSY_IFU};
    end

    assign mem_valid_o = valid_q;
    assign mem_addr_o  = addr_q;
    assign mem_ren_o   = ren_q;
    assign mem_wen_o   = wen_q;
    assign mem_mask_o  = mask_q;
    assign mem_size_o  = size_q;
    assign mem_wdata_o = wdata_q;

endmodule
